// File: rtl/axis_burst_pkg.sv
// axis_burst_pkg: state encoding and default widths for the burst transmitter
package axis_burst_pkg;
  typedef enum logic {IDLE_S = 1'b0, SEND_S = 1'b1} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/axis_burst_tx.sv
// axis_burst_tx: command-driven AXI-Stream master emitting start+k*step bursts
module axis_burst_tx
  import axis_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] cmd_start_i,
  input  logic [DATA_WIDTH-1:0] cmd_step_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tlast_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  bursts_o
);
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_step;
  logic [DATA_WIDTH-1:0] r_data;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ready;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_hs;
  assign w_hs = r_valid & tready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE_S;
      r_step  <= '0;
      r_data  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE_S) begin
        if (cmd_valid_i) begin
          r_state <= SEND_S;
          r_step  <= cmd_step_i;
          r_rem   <= cmd_len_i;
          r_data  <= cmd_start_i;
          r_last  <= (cmd_len_i == '0);
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end
      end else if (w_hs) begin
        if (r_last) begin
          r_state <= IDLE_S;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_cnt   <= r_cnt + CNT_WIDTH'(1);
        end else begin
          r_data <= r_data + r_step;
          r_rem  <= r_rem - LEN_WIDTH'(1);
          r_last <= (r_rem == LEN_WIDTH'(1));
        end
      end
    end
  end
  assign cmd_ready_o = r_ready;
  assign tvalid_o    = r_valid;
  assign tdata_o     = r_data;
  assign tlast_o     = r_last;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign bursts_o    = r_cnt;
endmodule

// File: tb/tb_axis_burst_tx.sv
// tb_axis_burst_tx: directed checks of burst sequencing, backpressure, wrap and reset abort
module tb_axis_burst_tx;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_start_i = '0;
  logic [7:0]  cmd_step_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic        tvalid_o;
  logic        tready_i = 1'b0;
  logic [7:0]  tdata_o;
  logic        tlast_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bursts_o;
  int total = 0;
  int passed = 0;
  int nb = 0;
  axis_burst_tx dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_start_i(cmd_start_i), .cmd_step_i(cmd_step_i), .cmd_len_i(cmd_len_i),
    .tvalid_o(tvalid_o), .tready_i(tready_i), .tdata_o(tdata_o), .tlast_o(tlast_o),
    .busy_o(busy_o), .done_o(done_o), .bursts_o(bursts_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic run_burst(input logic [7:0] st, input logic [7:0] sp, input logic [7:0] ln,
                           input logic [6:0] pat);
    logic [7:0] e;
    logic [7:0] hd;
    logic       hl;
    logic       held;
    int k;
    int cyc;
    cmd_valid_i = 1'b1;
    cmd_start_i = st;
    cmd_step_i  = sp;
    cmd_len_i   = ln;
    tick();
    cmd_valid_i = 1'b0;
    chk("accept_tvalid", tvalid_o, 1);
    chk("accept_cmd_ready", cmd_ready_o, 0);
    chk("accept_busy", busy_o, 1);
    e = st;
    k = 0;
    cyc = 0;
    held = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (k <= int'(ln) && cyc < 600) begin
      tready_i = (cyc < 7) ? pat[cyc] : 1'b1;
      if (held) begin
        chk("hold_tvalid", tvalid_o, 1);
        chk("hold_tdata", tdata_o, hd);
        chk("hold_tlast", tlast_o, hl);
      end
      if (tvalid_o && tready_i) begin
        chk("beat_tdata", tdata_o, e);
        chk("beat_tlast", tlast_o, k == int'(ln));
        e = e + sp;
        k++;
        held = 1'b0;
      end else begin
        held = tvalid_o;
        hd = tdata_o;
        hl = tlast_o;
      end
      tick();
      cyc++;
    end
    chk("burst_within_budget", cyc < 600, 1);
    if (pat == 7'h7F) chk("full_rate_cycles", cyc, int'(ln) + 1);
    nb++;
    chk("end_done", done_o, 1);
    chk("end_tvalid", tvalid_o, 0);
    chk("end_tlast", tlast_o, 0);
    chk("end_busy", busy_o, 0);
    chk("end_cmd_ready", cmd_ready_o, 1);
    chk("end_bursts", bursts_o, nb);
    tick();
    chk("done_one_cycle", done_o, 0);
    chk("idle_tvalid", tvalid_o, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_tvalid", tvalid_o, 0);
    chk("rst_tdata", tdata_o, 0);
    chk("rst_tlast", tlast_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_bursts", bursts_o, 0);
    run_burst(8'h10, 8'h01, 8'd3, 7'h7F);
    chk("idle_tdata_held", tdata_o, 8'h13);
    run_burst(8'h10, 8'h01, 8'd3, 7'b1101001);
    run_burst(8'hFE, 8'h01, 8'd3, 7'h7F);
    run_burst(8'h5A, 8'h00, 8'd0, 7'h7F);
    run_burst(8'h07, 8'h00, 8'd2, 7'b0110101);
    // Two queued commands: the second waits for the IDLE bubble after the first finishes
    tready_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_start_i = 8'h20;
    cmd_step_i = 8'h02;
    cmd_len_i = 8'd1;
    tick();
    cmd_start_i = 8'h40;
    cmd_step_i = 8'h03;
    cmd_len_i = 8'd2;
    chk("b2b_a0_data", tdata_o, 8'h20);
    chk("b2b_a0_last", tlast_o, 0);
    tick();
    chk("b2b_a1_data", tdata_o, 8'h22);
    chk("b2b_a1_last", tlast_o, 1);
    chk("b2b_a1_cmd_ready", cmd_ready_o, 0);
    tick();
    nb++;
    chk("b2b_gap_tvalid", tvalid_o, 0);
    chk("b2b_gap_done", done_o, 1);
    chk("b2b_gap_cmd_ready", cmd_ready_o, 1);
    chk("b2b_gap_bursts", bursts_o, nb);
    tick();
    cmd_valid_i = 1'b0;
    chk("b2b_b0_tvalid", tvalid_o, 1);
    chk("b2b_b0_data", tdata_o, 8'h40);
    chk("b2b_b0_done", done_o, 0);
    tick();
    chk("b2b_b1_data", tdata_o, 8'h43);
    tick();
    chk("b2b_b2_data", tdata_o, 8'h46);
    chk("b2b_b2_last", tlast_o, 1);
    tick();
    nb++;
    chk("b2b_end_done", done_o, 1);
    chk("b2b_end_bursts", bursts_o, nb);
    tick();
    // Reset after two of four beats must abort with no done pulse
    cmd_valid_i = 1'b1;
    cmd_start_i = 8'h10;
    cmd_step_i = 8'h01;
    cmd_len_i = 8'd3;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    chk("abort_pre_data", tdata_o, 8'h12);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    nb = 0;
    chk("abort_tvalid", tvalid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_bursts", bursts_o, 0);
    chk("abort_cmd_ready", cmd_ready_o, 1);
    tick();
    chk("abort_after_tvalid", tvalid_o, 0);
    chk("abort_after_done", done_o, 0);
    run_burst(8'h00, 8'h01, 8'hFF, 7'h7F);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axis_burst_tx.md
Name: axis_burst_tx

Overview:
- Command-driven AXI-Stream transmitter (master end of the stream interface).
- Accepts one burst command: start value, step, beat count. Emits the beats as an incrementing data sequence, with tlast on the final beat.
- Honours downstream backpressure with full AXI-Stream master rules.
- Feeds the stream register slices and sinks in the datapath; also serves as the traffic source for stream-path bring-up.

Parameters:
- DATA_WIDTH, 8: width of tdata_o, cmd_start_i and cmd_step_i.
- LEN_WIDTH, 8: width of cmd_len_i; burst length is cmd_len_i+1 beats, max 2^LEN_WIDTH.
- CNT_WIDTH, 16: width of the completed-burst counter.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready; high only in IDLE.
- cmd_start_i  in  DATA_WIDTH  tdata of first beat.
- cmd_step_i  in  DATA_WIDTH  increment between beats.
- cmd_len_i  in  LEN_WIDTH  beats minus one.
- tvalid_o  out  1  stream valid.
- tready_i  in  1  stream ready from downstream.
- tdata_o  out  DATA_WIDTH  stream data.
- tlast_o  out  1  final beat of burst.
- busy_o  out  1  high while in SEND.
- done_o  out  1  one-cycle pulse after final-beat handshake.
- bursts_o  out  CNT_WIDTH  count of completed bursts.

Behaviour:
- Reset (rst_i high at clock edge, synchronous, active-high):
  - State goes to IDLE.
  - cmd_ready_o=1; tvalid_o=0, tdata_o=0, tlast_o=0, busy_o=0, done_o=0, bursts_o=0.
  - Reset mid-burst aborts immediately. No further beats are sent and no done_o pulse is produced.
- States: IDLE, SEND. Encoding lives in the package.
- IDLE:
  - cmd_ready_o=1, tvalid_o=0.
  - On cmd_valid_i at edge N: latch step and remaining-count (=cmd_len_i), load tdata_o=cmd_start_i, set tlast_o=(cmd_len_i==0), set tvalid_o=1 and busy_o=1, go to SEND.
  - First beat is therefore visible at cycle N+1 (1-cycle command-to-data latency).
- SEND:
  - cmd_ready_o=0; cmd_valid_i is ignored.
  - Beat handshake = tvalid_o && tready_i.
  - Without a handshake, tdata_o/tlast_o/tvalid_o hold stable (AXI rule: valid never drops before handshake, data never changes).
  - Handshake on a non-last beat: tdata_o <= tdata_o+step (mod 2^DATA_WIDTH, wrap silently); remaining-count decrements; tlast_o <= (remaining-count==1).
  - Handshake on the last beat (tlast_o=1): tvalid_o<=0, tlast_o<=0, busy_o<=0, done_o<=1 for one cycle, bursts_o increments (wraps at 2^CNT_WIDTH), go to IDLE.
- tvalid_o is never gated combinationally by tready_i. All outputs are registered.
- Back-to-back commands: the earliest next command acceptance is the cycle after the last-beat handshake (one IDLE bubble). This is accepted; the throughput loss is 1 cycle per burst.
- Full-rate streaming: with tready_i held high, one beat per cycle, so a burst of L+1 beats occupies L+1 consecutive cycles.
- Max length: cmd_len_i = 2^LEN_WIDTH-1 gives 2^LEN_WIDTH beats. The remaining-count register is LEN_WIDTH bits and does not overflow.
- step=0 is legal and yields constant data.
- tdata_o holds its last value in IDLE (not cleared). Only reset clears it.

Decomposition:
- Package axis_burst_pkg: state localparams IDLE_S=1'b0, SEND_S=1'b1, plus default width constants.
- No sub-module. The counter, data accumulator and FSM are small enough for one module (~150 lines).

Test Plan:
- Reset, then cmd start=8'h10 step=1 len=3, tready_i=1 -> tdata 10,11,12,13 on 4 consecutive cycles from N+1; tlast only on 13; done_o pulse next cycle; bursts_o=1.
- Same cmd with tready_i toggling 1,0,0,1,0,1,1 -> no beat lost or duplicated; tdata/tlast stable while tready_i=0; sequence still 10..13.
- cmd start=8'hFE step=8'h01 len=3 -> tdata FE,FF,00,01 (wrap); len=0 -> single beat with tlast=1 on first beat.
- cmd_valid_i held high for two queued commands -> second accepted only once cmd_ready_o=1 after first done; one-cycle gap in tvalid_o; bursts_o=2.
- rst_i asserted mid-burst (after 2 of 4 beats) -> next cycle tvalid_o=0, busy_o=0, no done_o, bursts_o=0, cmd_ready_o=1.
- len=8'hFF, tready_i=1 -> exactly 256 beats, tlast on beat 256 only.
